ifetch_queue: RTL and testbench

- Fetch-side consumer of the program counter register.
- Each cycle it takes the current pc, issues an instruction-memory request for it, and buffers returned instructions in a small in-order queue for the decode stage.
- Generates the stall signal that holds the pc register when a fetch cannot be accepted.
- Discards in-flight and queued instructions on a control-flow redirect (flush).

---
 rtl/ifetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch request engine with in-order decode queue
module ifetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [ADDR_W-1:0]        pc,
  output logic                     stall,
  input  logic                     flush,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [DATA_W-1:0]        dec_instr,
  output logic [ADDR_W-1:0]        dec_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state, state_next;
  logic [ADDR_W-1:0] req_pc;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count_q, count_next;
  logic              kill, push, pop, in_req;

  // run=0 is treated exactly like a flush held high
  assign kill   = flush | ~run;
  assign in_req = (state == S_REQ);

  assign imem_req  = in_req & ~kill;
  assign imem_addr = in_req ? pc : '0;

  // pc only moves when its fetch is granted, and always moves on a redirect
  assign stall = rst_n & run & ~flush & ~(imem_req & imem_gnt);

  // a response is kept only when it arrives for a live request
  assign push = (state == S_WAIT) & imem_rvalid & ~kill;
  assign pop  = dec_ready & dec_valid & ~kill;

  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

  assign count     = count_q;
  assign dec_valid = (count_q != '0);
  assign dec_instr = dec_valid ? instr_mem[head] : '0;
  assign dec_pc    = dec_valid ? pc_mem[head] : '0;

  // next-state logic; credit reserves a slot for the single outstanding request
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!kill && (count_q < DEPTH_C))
          state_next = S_REQ;
      end
      S_REQ: begin
        if (kill)
          state_next = imem_gnt ? S_DRAIN : S_IDLE;
        else if (imem_gnt)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (kill)
          state_next = imem_rvalid ? S_IDLE : S_DRAIN;
        else if (imem_rvalid)
          state_next = (count_next < DEPTH_C) ? S_REQ : S_IDLE;
      end
      default: begin
        if (imem_rvalid)
          state_next = S_IDLE;
      end
    endcase
  end

  // state register and address of the request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      req_pc <= '0;
    end else begin
      state <= state_next;
      if (imem_req && imem_gnt)
        req_pc <= pc;
    end
  end

  // queue pointers and occupancy; a kill empties the queue and drops any pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (kill) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      count_q <= count_next;
    end
  end

  // queue storage; contents are only visible through a valid head
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= imem_rdata;
      pc_mem[tail]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - scoreboard bench for ifetch_queue
module tb_ifetch_queue;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0]  count;

  logic        gnt_en;
  logic [31:0] target;
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          rdelay;
  int          n_gnt;
  logic        last_fire_gnt;
  logic [31:0] last_gnt_addr;
  logic [31:0] exp_q[$];
  int          n_pass;
  int          n_checks;
  int          g0;
  logic        found;

  ifetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc(pc), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory only grants what is actually requested
  assign imem_gnt = gnt_en & imem_req;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // one clock: sample at negedge, update pc register and memory just after posedge
  task automatic tick();
    logic        fire_pop;
    logic        fire_gnt;
    logic        hold;
    logic [31:0] e;
    @(negedge clk);
    fire_pop = dec_valid && dec_ready && !flush && run;
    if (fire_pop) begin
      if (exp_q.size() == 0) check("sb_underflow", 64'(dec_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("dec_pc", 64'(dec_pc), 64'(e));
        check("dec_instr", 64'(dec_instr), 64'(mem_data(e)));
      end
    end
    if (flush || !run) exp_q.delete();
    fire_gnt = imem_req && imem_gnt;
    if (fire_gnt) begin
      check("gnt_addr", 64'(imem_addr), 64'(pc));
      exp_q.push_back(pc);
      n_gnt++;
      last_gnt_addr = pc;
    end
    hold = stall;
    @(posedge clk);
    #1;
    if (!hold) pc = flush ? target : pc + 32'd4;
    flush = 1'b0;
    imem_rvalid = 1'b0;
    if (fire_gnt) begin
      mem_pend = 1'b1;
      mem_addr = last_gnt_addr;
      mem_cnt  = rdelay;
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(mem_addr);
        mem_pend    = 1'b0;
      end else mem_cnt--;
    end
    last_fire_gnt = fire_gnt;
  endtask

  initial begin
    n_pass = 0; n_checks = 0; n_gnt = 0;
    rst_n = 1'b0; run = 1'b1; pc = 32'h0; flush = 1'b0; target = 32'h0;
    gnt_en = 1'b1; dec_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mem_pend = 1'b0; mem_addr = 32'h0; mem_cnt = 0; rdelay = 0;
    last_fire_gnt = 1'b0; last_gnt_addr = 32'h0;

    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_dec_pc", 64'(dec_pc), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // straight-line fetch: first head must be 0x00
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (dec_valid) found = 1'b1;
    end
    check("sl_first_valid", 64'(found), 64'd1);
    check("sl_first_pc", 64'(dec_pc), 64'h0);
    for (int i = 0; i < 16; i++) tick();

    // back-pressure: fill to DEPTH, fetch stops and pc is held
    dec_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (count == 3'd4 && !imem_req) found = 1'b1;
    end
    check("bp_full", 64'(found), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_count", 64'(count), 64'd4);
      check("bp_req", 64'(imem_req), 64'd0);
      check("bp_stall", 64'(stall), 64'd1);
      tick();
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    g0 = n_gnt;
    for (int i = 0; i < 8; i++) tick();
    check("bp_one_req", 64'(n_gnt - g0), 64'd1);
    check("bp_refill", 64'(count), 64'd4);
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // grant delay: redirect to 0x10, hold grant low for three cycles
    gnt_en = 1'b0;
    flush = 1'b1; target = 32'h10;
    tick();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1'b1;
      else tick();
    end
    check("gd_req_seen", 64'(found), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("gd_addr", 64'(imem_addr), 64'h10);
      check("gd_stall", 64'(stall), 64'd1);
      tick();
    end
    gnt_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (dec_valid) found = 1'b1;
    end
    check("gd_head_valid", 64'(found), 64'd1);
    check("gd_head_pc", 64'(dec_pc), 64'h10);
    for (int i = 0; i < 6; i++) tick();

    // run=0 behaves as a continuous flush
    run = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("run0_req", 64'(imem_req), 64'd0);
    check("run0_count", 64'(count), 64'd0);
    check("run0_stall", 64'(stall), 64'd0);
    run = 1'b1;
    rdelay = 2;

    // flush in WAIT: the 0x20 response must be dropped
    flush = 1'b1; target = 32'h20;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (last_fire_gnt && last_gnt_addr == 32'h20) found = 1'b1;
    end
    check("fw_gnt_20", 64'(found), 64'd1);
    flush = 1'b1; target = 32'h100;
    tick();
    check("fw_count", 64'(count), 64'd0);
    check("fw_dec_valid", 64'(dec_valid), 64'd0);
    rdelay = 0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (dec_valid) found = 1'b1;
    end
    check("fw_head_valid", 64'(found), 64'd1);
    check("fw_head_pc", 64'(dec_pc), 64'h100);
    check("fw_head_instr", 64'(dec_instr), 64'(mem_data(32'h100)));

    // push and pop together at count=DEPTH-1
    flush = 1'b1; target = 32'h200;
    dec_ready = 1'b0;
    tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (count == 3'd3 && imem_rvalid) found = 1'b1;
      else tick();
    end
    check("pp_setup", 64'(found), 64'd1);
    dec_ready = 1'b1;
    tick();
    check("pp_count", 64'(count), 64'd3);
    for (int i = 0; i < 16; i++) tick();

    // async reset mid-WAIT, off-edge
    rdelay = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (last_fire_gnt) found = 1'b1;
    end
    check("ar_in_wait", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_dec_valid", 64'(dec_valid), 64'd0);
    check("ar_req", 64'(imem_req), 64'd0);
    check("ar_stall", 64'(stall), 64'd0);
    check("ar_addr", 64'(imem_addr), 64'd0);
    mem_pend = 1'b0; imem_rvalid = 1'b0; exp_q.delete();
    rdelay = 0;
    @(posedge clk); #1;
    pc = 32'h300;
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (last_fire_gnt) found = 1'b1;
    end
    check("ar_first_gnt", 64'(found), 64'd1);
    check("ar_first_addr", 64'(last_gnt_addr), 64'h300);
    for (int i = 0; i < 10; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
